// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite initiator turning local commands into bus transfers
module axi4_lite_master #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS-1:0]      cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDRESS-1:0]      M_AWADDR,
    output logic [2:0]              M_AWPROT,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    output logic [ADDRESS-1:0]      M_ARADDR,
    output logic [2:0]              M_ARPROT,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RVALID,
    output logic                    M_RREADY
);
    localparam int SW = DATA_WIDTH / 8;
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;
    state_t                state_q, state_d;
    logic [ADDRESS-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic arvalid_q, arvalid_d, rready_q, rready_d;
    logic rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic aw_done, w_done;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        aw_done     = !awvalid_q || M_AWREADY;
        w_done      = !wvalid_q || M_WREADY;
        unique case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d    = cmd_addr & ~ADDRESS'(3);
                wdata_d   = cmd_wdata;
                wstrb_d   = cmd_wstrb;
                awvalid_d = cmd_write;
                wvalid_d  = cmd_write;
                arvalid_d = !cmd_write;
                state_d   = cmd_write ? WRITE : READ;
            end
            WRITE: begin
                // AW and W complete independently; a dropped VALID marks its channel done
                awvalid_d = awvalid_q && !M_AWREADY;
                wvalid_d  = wvalid_q && !M_WREADY;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: if (M_BVALID) begin
                bready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_resp_d  = M_BRESP;
                state_d     = RESP;
            end
            READ: if (M_ARREADY) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = RDATA;
            end
            RDATA: if (M_RVALID) begin
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b0;
                rsp_rdata_d = M_RDATA;
                rsp_resp_d  = M_RRESP;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign M_AWADDR  = addr_q;
    assign M_ARADDR  = addr_q;
    assign M_AWPROT  = 3'b000;
    assign M_ARPROT  = 3'b000;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = rready_q;
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: randomized scoreboard bench with a memory-backed slave model and protocol monitor
module tb_axi4_lite_master;
    logic ACLK = 1'b0, ARESETN = 1'b0;
    logic cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0, cmd_wdata = 0;
    logic [3:0] cmd_wstrb = 0;
    logic rsp_valid, rsp_ready = 0, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA = 0;
    logic [2:0] M_AWPROT, M_ARPROT;
    logic [3:0] M_WSTRB;
    logic M_AWVALID, M_AWREADY = 0, M_WVALID, M_WREADY = 0, M_BVALID = 0, M_BREADY;
    logic M_ARVALID, M_ARREADY = 0, M_RVALID = 0, M_RREADY;
    logic [1:0] M_BRESP = 0, M_RRESP = 0;

    axi4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int total = 0, bad = 0;
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0, rsp_dly = 0;
    int last_rsp_len = 0;
    logic [31:0] mmem [32];
    logic [31:0] smem [32];
    logic [34:0] exp_q [$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // reference model: word memory indexed by addr[6:2], response code taken from addr[9:8]
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit hold);
        int n = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        if (w) begin
            for (int b = 0; b < 4; b++) if (s[b]) mmem[a[6:2]][8*b +: 8] = d[8*b +: 8];
            exp_q.push_back({1'b1, 32'h0, a[9:8]});
        end else exp_q.push_back({1'b0, mmem[a[6:2]], a[9:8]});
        while (!cmd_ready) begin
            @(negedge ACLK);
            if (++n > 500) begin
                $display("FAIL cmd_accept timeout");
                $fatal(1, "command never accepted");
            end
        end
        @(negedge ACLK);
        if (!hold) cmd_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid || !cmd_ready) && n < 1000) begin
            @(negedge ACLK);
            n++;
        end
        chk("drain", {31'd0, exp_q.size() != 0}, 0);
    endtask

    // slave: per-channel ready/valid delays; writes land in smem once both AW and W arrive
    initial begin
        bit aw_got = 0, w_got = 0, ar_got = 0, b_wait = 0, r_wait = 0, bhs = 0, rhs = 0;
        int aw_c = 0, w_c = 0, ar_c = 0, b_c = 0, r_c = 0;
        logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;
        logic [3:0] s_wstrb = 0;
        for (int i = 0; i < 32; i++) smem[i] = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                {M_AWREADY, M_WREADY, M_ARREADY, M_BVALID, M_RVALID} = '0;
                {aw_got, w_got, ar_got, b_wait, r_wait, bhs, rhs} = '0;
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
            end else begin
                M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0;
                if (bhs) M_BVALID = 0;
                if (rhs) M_RVALID = 0;
                if (M_AWVALID && !aw_got) begin if (aw_c >= aw_dly) M_AWREADY = 1; else aw_c++; end
                if (M_WVALID && !w_got) begin if (w_c >= w_dly) M_WREADY = 1; else w_c++; end
                if (M_ARVALID && !ar_got) begin if (ar_c >= ar_dly) M_ARREADY = 1; else ar_c++; end
                if (aw_got && w_got) begin
                    for (int b = 0; b < 4; b++) if (s_wstrb[b]) smem[s_awaddr[6:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    aw_got = 0; w_got = 0; b_wait = 1; b_c = 0;
                end
                if (b_wait) begin
                    if (b_c >= b_dly) begin M_BVALID = 1; M_BRESP = s_awaddr[9:8]; b_wait = 0; end
                    else b_c++;
                end
                if (ar_got) begin ar_got = 0; r_wait = 1; r_c = 0; end
                if (r_wait) begin
                    if (r_c >= r_dly) begin
                        M_RVALID = 1; M_RDATA = smem[s_araddr[6:2]]; M_RRESP = s_araddr[9:8]; r_wait = 0;
                    end else r_c++;
                end
                if (M_AWVALID && M_AWREADY) begin aw_got = 1; aw_c = 0; s_awaddr = M_AWADDR; end
                if (M_WVALID && M_WREADY) begin w_got = 1; w_c = 0; s_wdata = M_WDATA; s_wstrb = M_WSTRB; end
                if (M_ARVALID && M_ARREADY) begin ar_got = 1; ar_c = 0; s_araddr = M_ARADDR; end
                bhs = M_BVALID && M_BREADY;
                rhs = M_RVALID && M_RREADY;
            end
        end
    end

    initial begin
        int rc = 0;
        forever begin
            @(negedge ACLK);
            if (!rsp_valid) begin rsp_ready = 0; rc = 0; end
            else if (rc >= rsp_dly) rsp_ready = 1;
            else begin rsp_ready = 0; rc++; end
        end
    end

    // monitor: sampled mid-cycle, after all negedge drives, so handshakes seen here happen at the next posedge
    initial begin
        bit p_ok = 0, p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0, p_arv = 0, p_arhs = 0, p_rv = 0, p_rhs = 0;
        logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
        logic [3:0] p_wstrb = 0;
        logic [34:0] p_rsp = 0, e;
        int rlen = 0;
        forever begin
            @(negedge ACLK);
            #2;
            if (!ARESETN) begin
                p_ok = 0; rlen = 0;
                continue;
            end
            if (p_ok) begin
                if (p_awv && !p_awhs) chk("aw_hold", {M_AWVALID, M_AWADDR}, {1'b1, p_awaddr});
                if (p_awhs) chk("aw_drop", M_AWVALID, 0);
                if (p_wv && !p_whs) chk("w_hold", {M_WVALID, M_WDATA, M_WSTRB}, {1'b1, p_wdata, p_wstrb});
                if (p_whs) chk("w_drop", M_WVALID, 0);
                if (p_arv && !p_arhs) chk("ar_hold", {M_ARVALID, M_ARADDR}, {1'b1, p_araddr});
                if (p_arhs) chk("ar_drop", M_ARVALID, 0);
                if (p_rv && !p_rhs) chk("rsp_hold", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {1'b1, p_rsp});
                if (p_rhs) chk("idle_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
            end
            if (M_AWVALID) chk("aw_align_prot", {M_AWADDR[1:0], M_AWPROT}, 0);
            if (M_ARVALID) chk("ar_align_prot", {M_ARADDR[1:0], M_ARPROT}, 0);
            if (M_BREADY) chk("bready_early", {M_AWVALID, M_WVALID}, 0);
            if (M_AWVALID || M_WVALID || M_BREADY) chk("channel_overlap", {M_ARVALID, M_RREADY}, 0);
            if (rsp_valid || M_AWVALID || M_WVALID || M_BREADY || M_ARVALID || M_RREADY)
                chk("cmd_ready_busy", cmd_ready, 0);
            if (rsp_valid) rlen++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got %0h want none", {rsp_write, rsp_rdata, rsp_resp});
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", {rsp_write, rsp_rdata, rsp_resp}, e);
                end
                last_rsp_len = rlen;
                rlen = 0;
            end
            p_ok = 1;
            p_awv = M_AWVALID; p_awhs = M_AWVALID && M_AWREADY; p_awaddr = M_AWADDR;
            p_wv = M_WVALID; p_whs = M_WVALID && M_WREADY; p_wdata = M_WDATA; p_wstrb = M_WSTRB;
            p_arv = M_ARVALID; p_arhs = M_ARVALID && M_ARREADY; p_araddr = M_ARADDR;
            p_rv = rsp_valid; p_rhs = rsp_valid && rsp_ready; p_rsp = {rsp_write, rsp_rdata, rsp_resp};
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mmem[i] = 0;
        #2;
        chk("rst_valids", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_addr", {M_AWADDR, M_ARADDR}, 0);
        chk("rst_data", {M_WDATA, rsp_rdata}, 0);
        chk("rst_misc", {M_WSTRB, rsp_resp, rsp_write, M_AWPROT, M_ARPROT}, 0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1;
        @(negedge ACLK);
        issue(1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0);
        wait_done();
        aw_dly = 3;
        issue(1, 32'h0000_0010, 32'h12345678, 4'hF, 0);
        wait_done();
        aw_dly = 0; ar_dly = 4;
        issue(0, 32'h0000_0013, 0, 0, 0);
        wait_done();
        ar_dly = 0; rsp_dly = 5;
        issue(0, 32'h0000_0204, 0, 0, 0);
        wait_done();
        chk("rsp_stall_len", last_rsp_len, 6);
        rsp_dly = 0; b_dly = 2;
        issue(1, 32'h0000_0108, 32'hA5A5_0F0F, 4'b0101, 1);
        issue(0, 32'h0000_0108, 0, 0, 0);
        wait_done();
        b_dly = 0; aw_dly = 100;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
        @(negedge ACLK);
        cmd_valid = 0;
        repeat (3) @(negedge ACLK);
        chk("pre_rst_awvalid", M_AWVALID, 1);
        ARESETN = 0;
        #1;
        chk("async_rst_valids", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1;
        aw_dly = 0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        @(negedge ACLK);
        issue(0, 32'h0000_0040, 0, 0, 0);
        wait_done();
        for (int t = 0; t < 200; t++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); rsp_dly = $urandom_range(0, 3);
            issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                  t != 199 && $urandom_range(0, 1) == 1);
        end
        wait_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator.
- Turns one local command (read or write) into the matching AXI4-Lite channel handshakes, then returns the response on a local response port.
- Sits between the register-access sequencers and `axi4_lite_slave`-style targets on the 32-register bus.

Parameters:
- ADDRESS, 32: AXI address width in bits.
- DATA_WIDTH, 32: AXI data width in bits. Must be 32 or 64. Strobe width is DATA_WIDTH/8.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDRESS  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echoes cmd_write of the completed transfer
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP or RRESP of the transfer
- M_AWADDR  out  ADDRESS;  M_AWPROT  out  3;  M_AWVALID  out  1;  M_AWREADY  in  1
- M_WDATA  out  DATA_WIDTH;  M_WSTRB  out  DATA_WIDTH/8;  M_WVALID  out  1;  M_WREADY  in  1
- M_BRESP  in  2;  M_BVALID  in  1;  M_BREADY  out  1
- M_ARADDR  out  ADDRESS;  M_ARPROT  out  3;  M_ARVALID  out  1;  M_ARREADY  in  1
- M_RDATA  in  DATA_WIDTH;  M_RRESP  in  2;  M_RVALID  in  1;  M_RREADY  out  1

Behaviour:
- Reset (ARESETN low, asynchronous):
  - state = IDLE.
  - All VALID/READY outputs and rsp_valid = 0.
  - All address, data, strobe, resp and rsp_* registers = 0.
  - Reset mid-transfer abandons the transfer with no response.
- All outputs are registered. AWPROT = ARPROT = 3'b000 always.
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - cmd_ready = 1 (combinational from state); cmd_ready = 0 in all other states.
  - On cmd_valid: capture the command. The address is sent word-aligned (addr[1:0] forced to 0).
  - Write: go to WRITE, with AWVALID = WVALID = 1 from the next cycle.
  - Read: go to READ, with ARVALID = 1 from the next cycle.
- WRITE:
  - AW and W are independent. Each VALID is held, with stable payload, until its own handshake, then drops the following cycle.
  - Internal aw_done/w_done flags record completion.
  - Both handshakes in the same cycle, or in either order, are legal.
  - When both are done, go to WRESP with BREADY = 1.
  - Minimum IDLE-to-WRESP latency is 2 cycles.
- WRESP:
  - BREADY held at 1.
  - On BVALID: capture BRESP, rsp_rdata = 0, rsp_write = 1, BREADY drops, go to RESP.
- READ:
  - ARVALID held until ARREADY, then go to RDATA with RREADY = 1.
- RDATA:
  - RREADY held at 1.
  - On RVALID: capture RDATA/RRESP, rsp_write = 0, go to RESP.
- RESP:
  - rsp_valid = 1 and payload held stable until rsp_ready.
  - Then rsp_valid drops and the state returns to IDLE.
  - A new command can be accepted the cycle after the rsp handshake; cmd_ready is never 1 in the same cycle as the rsp handshake.
- VALID outputs never depend combinationally on READY inputs.
- VALID is never withdrawn before its handshake.
- SLVERR/DECERR responses are passed through unchanged; the command is not retried.
- BVALID/RVALID arriving outside WRESP/RDATA is ignored (BREADY/RREADY are 0 then).

Test Plan:
- Write cmd addr 0x0000_0010, data 0xDEADBEEF, strobe 0xF; slave gives AWREADY and WREADY in the same cycle, BRESP = 0 -> AW and W each valid for exactly 1 cycle; rsp_valid with rsp_resp = 0, rsp_write = 1, rsp_rdata = 0.
- Write with WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID held with AWADDR stable; BREADY rises only after both handshakes; exactly one response.
- Read addr 0x0000_0013, ARREADY delayed 4 cycles, RDATA 0x12345678 -> ARADDR = 0x0000_0010 held stable while stalled; rsp_rdata = 0x12345678, rsp_resp = 0.
- Read returns RRESP = 2'b10 while rsp_ready is held low 5 cycles -> rsp_valid and payload stable for 5 cycles; cmd_ready = 0 throughout; IDLE reached the cycle after rsp_ready.
- Back-to-back write then read with cmd_valid held high -> second command accepted only after the first response handshake; no overlap between AW/W and AR channels.
- ARESETN asserted while AWVALID is high mid-write -> all VALID/READY outputs and rsp_valid go to 0 asynchronously; after release, cmd_ready = 1 and a fresh read completes normally.
